cg_phase_sequencer: RTL and testbench
=====================================

# cg_phase_sequencer

Top-level phase scheduler for the conjugate-gradient datapath. Latches a solve request, then steps the shared vector/matrix units through one CG iteration at a time (q=A·p, p·q, α, x/r update, r·r, convergence check, β, p update). Streams block read addresses to the active unit and counts iterations until convergence or the iteration limit. Sits above the memory address controller and vector units, replacing ad-hoc flag chaining between them.

## Interface
- NO_OF_UNITS, 8, parallel lanes per block; power of two
- ADDR_WIDTH, 32, block address width
- ITER_WIDTH, 11, iteration counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle solve request
- total  in  32  vector length in elements; latched on accepted start
- max_iter  in  ITER_WIDTH  iteration limit; latched on accepted start; 0 treated as 1
- converged  in  1  residual-below-threshold flag, sampled only in CHECK
- phase_id  out  4  current phase encoding (package enum)
- phase_start  out  1  one-cycle pulse, first cycle of each non-IDLE/CHECK/FINISH phase
- rd_addr  out  ADDR_WIDTH  block address for the active streaming unit
- rd_valid  out  1  rd_addr valid
- rd_ready  in  1  active unit accepts rd_addr
- unit_done  in  1  active unit finished its phase
- iteration  out  ITER_WIDTH  completed iterations
- busy  out  1  high from accepted start until FINISH exit
- done  out  1  one-cycle pulse on FINISH
- halt  out  1  set on FINISH, held until next accepted start or reset

## Operation
- blocks = ceil(total / NO_OF_UNITS), computed by shift and round-up at start.
- States: IDLE, MXV, DOT_PQ, ALPHA, UPD_XR, DOT_RR, CHECK, BETA, UPD_P, FINISH.
- Streaming phases (MXV, DOT_PQ, UPD_XR, DOT_RR, UPD_P): rd_valid high, rd_addr 0..blocks-1; advances only when rd_valid & rd_ready; rd_valid drops after blocks-1 accepted.
- Scalar phases (ALPHA, BETA): no stream; rd_valid low.
- unit_done is latched (sticky) anywhere inside a phase after its phase_start cycle; phase exits when stream complete AND latch set. Latch cleared on phase exit.
- Order: MXV→DOT_PQ→ALPHA→UPD_XR→DOT_RR→CHECK→BETA→UPD_P→MXV.
- CHECK (1 cycle): iteration+=1; if converged or iteration+1 ≥ max_iter → FINISH else BETA.
- FINISH (1 cycle): done=1, halt←1, busy←0, next IDLE.
- start ignored when busy or total==0.
- Reset values: state IDLE, phase_id IDLE, rd_addr 0, rd_valid 0, phase_start 0, iteration 0, busy 0, done 0, halt 0.

## Timing
- start in IDLE at cycle n → cycle n+1: state MXV, phase_start=1, rd_valid=1, rd_addr=0, busy=1.
- With rd_ready held high: last address at cycle n+blocks; earliest phase exit cycle after both stream end and done latch; next phase_start one cycle after exit condition.
- unit_done coincident with last accepted address: exit next cycle.
- unit_done on the phase_start cycle is counted.
- Reset mid-solve: all outputs reset values next cycle; iteration and halt cleared.
- iteration wraps never: max_iter bounds it below 2^ITER_WIDTH.

## Configuration
- CG_PERF_CNT_EN defined: adds outputs cycle_count (32, busy cycles of last/current solve) and stall_count (32, cycles with rd_valid & !rd_ready); both clear on accepted start and reset, saturate at all-ones.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Package cg_pkg: phase enum typedef (4-bit), NO_OF_UNITS default, log2 helper constant.
- Sub-module cg_block_addr_gen: loadable block counter (load blocks, ready-gated increment, last flag); instantiated once.

## Test plan
- total=64, max_iter=3, converged=0, rd_ready=1, unit_done 2 cycles after each stream end → 3 full iterations, 8 addresses per streaming phase, iteration=3, one done pulse, halt=1.
- total=20 (blocks=3), converged=1 at first CHECK → addresses 0,1,2 per phase; FINISH after first CHECK; BETA never entered; iteration=1.
- rd_ready toggling 1,0,1,0 in MXV with total=32 → 4 addresses over 7 cycles, rd_addr held during stalls; stall_count=3 when CG_PERF_CNT_EN.
- unit_done pulsed on phase_start cycle of ALPHA and mid-stream of DOT_PQ → both phases exit normally, no lost done.
- start while busy and start with total=0 → ignored, state/iteration unchanged.
- reset asserted in UPD_XR of iteration 2 → next cycle IDLE, iteration=0, busy=0, halt=0; fresh start runs cleanly.

Source files
------------

// File: rtl/cg_pkg.sv
// Shared types and helpers for the conjugate-gradient phase sequencer.
package cg_pkg;

  typedef enum logic [3:0] {
    PH_IDLE   = 4'd0,
    PH_MXV    = 4'd1,
    PH_DOT_PQ = 4'd2,
    PH_ALPHA  = 4'd3,
    PH_UPD_XR = 4'd4,
    PH_DOT_RR = 4'd5,
    PH_CHECK  = 4'd6,
    PH_BETA   = 4'd7,
    PH_UPD_P  = 4'd8,
    PH_FINISH = 4'd9
  } phase_t;

  localparam int CG_NO_OF_UNITS = 8;

  function automatic int cg_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int CG_LOG2_UNITS = cg_log2(CG_NO_OF_UNITS);

  function automatic logic is_stream_phase(input phase_t p);
    return (p == PH_MXV) || (p == PH_DOT_PQ) || (p == PH_UPD_XR) ||
           (p == PH_DOT_RR) || (p == PH_UPD_P);
  endfunction

  function automatic logic is_scalar_phase(input phase_t p);
    return (p == PH_ALPHA) || (p == PH_BETA);
  endfunction

  // CHECK and FINISH are sequenced explicitly by the FSM, not here.
  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_MXV:    n = PH_DOT_PQ;
      PH_DOT_PQ: n = PH_ALPHA;
      PH_ALPHA:  n = PH_UPD_XR;
      PH_UPD_XR: n = PH_DOT_RR;
      PH_DOT_RR: n = PH_CHECK;
      PH_BETA:   n = PH_UPD_P;
      PH_UPD_P:  n = PH_MXV;
      default:   n = PH_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cg_block_addr_gen.sv
// Loadable block address counter: restarts at 0 on load, advances on each
// accepted address, flags the final block.
module cg_block_addr_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  adv,
  input  logic [ADDR_WIDTH-1:0] blocks,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] last_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      last_addr <= '0;
    end else if (load) begin
      addr      <= '0;
      last_addr <= blocks - ADDR_WIDTH'(1);
    end else if (adv && !last) begin
      addr <= addr + ADDR_WIDTH'(1);
    end
  end

  assign last = (addr == last_addr);

endmodule

// File: rtl/cg_phase_sequencer.sv
// CG iteration phase scheduler: sequences the vector/matrix units and streams
// block addresses. Optional perf counters enabled by defining CG_PERF_CNT_EN.
module cg_phase_sequencer
  import cg_pkg::*;
#(
  parameter int NO_OF_UNITS = CG_NO_OF_UNITS,
  parameter int ADDR_WIDTH  = 32,
  parameter int ITER_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           total,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  converged,
  output phase_t                phase_id,
  output logic                  phase_start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  unit_done,
  output logic [ITER_WIDTH-1:0] iteration,
  output logic                  busy,
  output logic                  done,
  output logic                  halt
`ifdef CG_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int LOG2_UNITS = cg_log2(NO_OF_UNITS);

  phase_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] blocks_q, blocks_calc, blocks_load;
  logic [ITER_WIDTH-1:0] max_iter_q, iter_q;
  logic [ITER_WIDTH:0]   iter_inc;
  logic                  busy_q, halt_q, rd_valid_q, phase_start_q;
  logic                  done_latch, stream_done;
  logic                  accept, handshake, addr_last, stream_end, done_seen;
  logic                  check_finish, active, entering, enter_stream;

  assign accept       = start && !busy_q && (total != 32'd0);
  assign handshake    = rd_valid_q && rd_ready;
  assign stream_end   = is_stream_phase(state) ? (stream_done || (handshake && addr_last)) : 1'b1;
  assign done_seen    = done_latch || unit_done;
  assign iter_inc     = {1'b0, iter_q} + (ITER_WIDTH + 1)'(1);
  assign check_finish = converged || (iter_inc >= {1'b0, max_iter_q});
  assign active       = is_stream_phase(state) || is_scalar_phase(state);
  assign entering     = (state_nxt != state);
  assign enter_stream = entering && is_stream_phase(state_nxt);

  // Round-up division by the lane count; the new value bypasses blocks_q on the start cycle.
  assign blocks_calc = ADDR_WIDTH'(total >> LOG2_UNITS) +
                       ADDR_WIDTH'(|(total & 32'(NO_OF_UNITS - 1)));
  assign blocks_load = accept ? blocks_calc : blocks_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      PH_IDLE:   if (accept) state_nxt = PH_MXV;
      PH_CHECK:  state_nxt = check_finish ? PH_FINISH : PH_BETA;
      PH_FINISH: state_nxt = PH_IDLE;
      default:   if (stream_end && done_seen) state_nxt = next_phase(state);
    endcase
  end

  // stage p0: phase state register
  always_ff @(posedge clk) begin
    if (reset) state <= PH_IDLE;
    else       state <= state_nxt;
  end

  // stage p0: control registers alongside the phase state
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_start_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      stream_done   <= 1'b0;
      done_latch    <= 1'b0;
      busy_q        <= 1'b0;
      halt_q        <= 1'b0;
      iter_q        <= '0;
    end else begin
      phase_start_q <= entering && (is_stream_phase(state_nxt) || is_scalar_phase(state_nxt));

      if (enter_stream)                 rd_valid_q <= 1'b1;
      else if (handshake && addr_last)  rd_valid_q <= 1'b0;

      if (entering)                     stream_done <= 1'b0;
      else if (handshake && addr_last)  stream_done <= 1'b1;

      if (entering)                     done_latch <= 1'b0;
      else if (active && unit_done)     done_latch <= 1'b1;

      if (accept)                       busy_q <= 1'b1;
      else if (state == PH_FINISH)      busy_q <= 1'b0;

      if (accept)                       halt_q <= 1'b0;
      else if (state == PH_FINISH)      halt_q <= 1'b1;

      if (accept)                       iter_q <= '0;
      else if (state == PH_CHECK)       iter_q <= iter_inc[ITER_WIDTH-1:0];
    end
  end

  // Solve parameters captured on accepted start; max_iter of 0 behaves as 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      blocks_q   <= blocks_calc;
      max_iter_q <= (max_iter == '0) ? ITER_WIDTH'(1) : max_iter;
    end
  end

  cg_block_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (enter_stream),
    .adv    (handshake),
    .blocks (blocks_load),
    .addr   (rd_addr),
    .last   (addr_last)
  );

  assign phase_id    = state;
  assign phase_start = phase_start_q;
  assign rd_valid    = rd_valid_q;
  assign iteration   = iter_q;
  assign busy        = busy_q;
  assign done        = (state == PH_FINISH);
  assign halt        = halt_q;

`ifdef CG_PERF_CNT_EN
  logic [31:0] cycle_q, stall_q;

  // stage p1: saturating performance counters
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (busy_q && (cycle_q != '1))                     cycle_q <= cycle_q + 32'd1;
      if (rd_valid_q && !rd_ready && (stall_q != '1))    stall_q <= stall_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_cg_phase_sequencer.sv
// Scoreboard bench for cg_phase_sequencer: expected phase order and address
// beats are queued at start and popped as the DUT produces them.
module tb_cg_phase_sequencer;
  import cg_pkg::*;

  localparam int NU = 8;
  localparam int AW = 32;
  localparam int IW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   total = '0;
  logic [IW-1:0] max_iter = '0;
  logic          converged, rd_ready, unit_done;
  phase_t        phase_id;
  logic          phase_start, rd_valid, busy, done, halt;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] iteration;
`ifdef CG_PERF_CNT_EN
  logic [31:0]   cycle_count, stall_count;
`endif

  always #5 clk = ~clk;

  cg_phase_sequencer #(.NO_OF_UNITS(NU), .ADDR_WIDTH(AW), .ITER_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .total(total), .max_iter(max_iter),
    .converged(converged), .phase_id(phase_id), .phase_start(phase_start),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready), .unit_done(unit_done),
    .iteration(iteration), .busy(busy), .done(done), .halt(halt)
`ifdef CG_PERF_CNT_EN
    , .cycle_count(cycle_count), .stall_count(stall_count)
`endif
  );

  typedef struct { phase_t ph; logic [AW-1:0] a; } beat_t;
  beat_t  beat_q[$];
  phase_t ph_q[$];

  int n_total = 0;
  int n_bad   = 0;

  bit sb_en = 0;
  bit tog = 0;
  int resp_mode = 0, resp_d = 2, conv_at = 0, exp_blocks = 1;
  int pend = 0, chk_seen = 0, busy_cyc = 0, done_cnt = 0, xr_cnt = 0;
  bit prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;

  // Reactive unit model plus output monitor, evaluated mid-cycle.
  initial begin
    bit hs, trig;
    beat_t b;
    phase_t p;
    rd_ready = 1'b1; unit_done = 1'b0; converged = 1'b0;
    forever begin
      @(negedge clk);
      if (tog && phase_id == PH_MXV) rd_ready = phase_start ? 1'b1 : ~rd_ready;
      else                           rd_ready = 1'b1;
      converged = (phase_id == PH_CHECK) && (conv_at != 0) && (chk_seen + 1 == conv_at);
      if (phase_id == PH_CHECK) chk_seen++;
      hs = rd_valid && rd_ready;
      unit_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) unit_done = 1'b1;
      end
      if (resp_mode == 1) begin
        if (phase_start && (phase_id == PH_ALPHA || phase_id == PH_BETA)) unit_done = 1'b1;
        if (hs && rd_addr == AW'(1)) unit_done = 1'b1;
      end else begin
        trig = (phase_start && (phase_id == PH_ALPHA || phase_id == PH_BETA)) ||
               (hs && rd_addr == AW'(exp_blocks - 1));
        if (trig) begin
          if (resp_d == 0) unit_done = 1'b1;
          else             pend = resp_d;
        end
      end

      if (busy === 1'b1) busy_cyc++;
      if (phase_start === 1'b1 && phase_id == PH_UPD_XR) xr_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        n_total++;
        if (phase_id !== PH_FINISH) begin
          n_bad++; $display("FAIL done_phase: got %0d expected %0d", phase_id, PH_FINISH);
        end
      end
      if (sb_en) begin
        if (phase_start === 1'b1) begin
          n_total++;
          if (ph_q.size() == 0) begin
            n_bad++; $display("FAIL phase_order: got phase %0d expected none", phase_id);
          end else begin
            p = ph_q.pop_front();
            if (phase_id !== p) begin
              n_bad++; $display("FAIL phase_order: got %0d expected %0d", phase_id, p);
            end
          end
        end
        if (hs) begin
          n_total++;
          if (beat_q.size() == 0) begin
            n_bad++; $display("FAIL beat: got phase %0d addr %0d expected none", phase_id, rd_addr);
          end else begin
            b = beat_q.pop_front();
            if (phase_id !== b.ph || rd_addr !== b.a) begin
              n_bad++;
              $display("FAIL beat: got phase %0d addr %0d expected phase %0d addr %0d",
                       phase_id, rd_addr, b.ph, b.a);
            end
          end
        end
      end
      if (prev_stall && rd_valid === 1'b1) begin
        n_total++;
        if (rd_addr !== prev_addr) begin
          n_bad++; $display("FAIL stall_hold: got %0d expected %0d", rd_addr, prev_addr);
        end
      end
      prev_stall = (rd_valid === 1'b1) && !rd_ready;
      prev_addr  = rd_addr;
    end
  end

  task automatic push_phase(input phase_t p, input int bl);
    beat_t b;
    ph_q.push_back(p);
    if (p != PH_ALPHA && p != PH_BETA) begin
      for (int k = 0; k < bl; k++) begin
        b.ph = p; b.a = AW'(k);
        beat_q.push_back(b);
      end
    end
  endtask

  task automatic run_solve(input string nm, input int tot, input int mi, input int ca,
                           input int mode, input int d, input bit tg, input bit poke);
    int bl, n, sl, scl, ml, expc, cyc;
    bl  = (tot + NU - 1) / NU;
    n   = (mi == 0) ? 1 : mi;
    if (ca != 0 && ca < n) n = ca;
    sl  = (mode == 1) ? bl : bl + d;
    scl = (mode == 1) ? 1 : 1 + d;
    ml  = tg ? ((mode == 1) ? 2 * bl - 1 : 2 * bl - 1 + d) : sl;
    expc = (n - 1) * (ml + 4 * sl + 2 * scl + 1) + (ml + 3 * sl + scl + 2);
    for (int k = 1; k <= n; k++) begin
      push_phase(PH_MXV, bl); push_phase(PH_DOT_PQ, bl); push_phase(PH_ALPHA, bl);
      push_phase(PH_UPD_XR, bl); push_phase(PH_DOT_RR, bl);
      if (k < n) begin push_phase(PH_BETA, bl); push_phase(PH_UPD_P, bl); end
    end
    @(negedge clk);
    resp_mode = mode; resp_d = d; tog = tg; conv_at = ca; exp_blocks = bl;
    chk_seen = 0; busy_cyc = 0; done_cnt = 0; pend = 0; sb_en = 1;
    total = tot; max_iter = IW'(mi); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (phase_id !== PH_MXV || busy !== 1'b1 || rd_valid !== 1'b1 || rd_addr !== '0 || phase_start !== 1'b1) begin
      n_bad++;
      $display("FAIL %s first_cycle: got phase %0d busy %0b valid %0b addr %0d ps %0b expected 1 1 1 0 1",
               nm, phase_id, busy, rd_valid, rd_addr, phase_start);
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 4) begin total = 16; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    n_total++;
    if (done_cnt == 0) begin
      n_bad++; $display("FAIL %s timeout: got no done expected done within 20000 cycles", nm);
    end
    repeat (2) @(negedge clk);
    n_total++;
    if (iteration !== IW'(n)) begin
      n_bad++; $display("FAIL %s iteration: got %0d expected %0d", nm, iteration, n);
    end
    n_total++;
    if (halt !== 1'b1 || busy !== 1'b0 || phase_id !== PH_IDLE) begin
      n_bad++; $display("FAIL %s end_state: got halt %0b busy %0b phase %0d expected 1 0 0",
                        nm, halt, busy, phase_id);
    end
    n_total++;
    if (done_cnt != 1) begin
      n_bad++; $display("FAIL %s done_pulses: got %0d expected 1", nm, done_cnt);
    end
    n_total++;
    if (busy_cyc != expc) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, busy_cyc, expc);
    end
    n_total++;
    if (ph_q.size() != 0 || beat_q.size() != 0) begin
      n_bad++; $display("FAIL %s leftover: got %0d phases %0d beats expected 0 0", nm, ph_q.size(), beat_q.size());
    end
`ifdef CG_PERF_CNT_EN
    n_total++;
    if (cycle_count !== 32'(expc) || stall_count !== 32'(tg ? n * (bl - 1) : 0)) begin
      n_bad++; $display("FAIL %s perf: got cycles %0d stalls %0d expected %0d %0d",
                        nm, cycle_count, stall_count, expc, tg ? n * (bl - 1) : 0);
    end
`endif
    ph_q.delete(); beat_q.delete();
    sb_en = 0; tog = 0; conv_at = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (phase_id !== PH_IDLE || rd_addr !== '0 || rd_valid !== 1'b0 || phase_start !== 1'b0 ||
        iteration !== '0 || busy !== 1'b0 || done !== 1'b0 || halt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got phase %0d addr %0d valid %0b ps %0b iter %0d busy %0b done %0b halt %0b expected all 0",
               phase_id, rd_addr, rd_valid, phase_start, iteration, busy, done, halt);
    end
    reset = 1'b0;
  endtask

  task automatic test_full();        run_solve("full", 64, 3, 0, 0, 2, 1'b0, 1'b0); endtask
  task automatic test_converge();    run_solve("converge", 20, 10, 1, 0, 2, 1'b0, 1'b0); endtask
  task automatic test_stall();       run_solve("stall", 32, 1, 0, 0, 1, 1'b1, 1'b0); endtask
  task automatic test_done_early();  run_solve("done_early", 24, 2, 0, 1, 0, 1'b0, 1'b0); endtask
  task automatic test_coincident();  run_solve("coincident", 8, 0, 0, 0, 0, 1'b0, 1'b0); endtask

  task automatic test_ignored_start();
    run_solve("busy_start", 40, 2, 0, 0, 1, 1'b0, 1'b1);
    @(negedge clk);
    total = 0; max_iter = IW'(4); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b0 || phase_id !== PH_IDLE || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_total_start: got busy %0b phase %0d valid %0b expected 0 0 0",
                        busy, phase_id, rd_valid);
    end
    repeat (2) @(negedge clk);
    n_total++;
    if (iteration !== IW'(2) || halt !== 1'b1) begin
      n_bad++; $display("FAIL zero_total_hold: got iter %0d halt %0b expected 2 1", iteration, halt);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    sb_en = 0; resp_mode = 0; resp_d = 1; tog = 0; conv_at = 0; exp_blocks = 2;
    xr_cnt = 0; chk_seen = 0; pend = 0;
    total = 16; max_iter = IW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (xr_cnt < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (phase_id !== PH_UPD_XR || iteration !== IW'(1)) begin
      n_bad++; $display("FAIL pre_reset: got phase %0d iter %0d expected %0d 1", phase_id, iteration, PH_UPD_XR);
    end
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (phase_id !== PH_IDLE || iteration !== '0 || busy !== 1'b0 || halt !== 1'b0 ||
        rd_valid !== 1'b0 || phase_start !== 1'b0 || done !== 1'b0 || rd_addr !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got phase %0d iter %0d busy %0b halt %0b valid %0b ps %0b done %0b addr %0d expected all 0",
               phase_id, iteration, busy, halt, rd_valid, phase_start, done, rd_addr);
    end
    reset = 1'b0;
    pend = 0;
    run_solve("after_reset", 16, 2, 0, 0, 2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full();
    test_converge();
    test_stall();
    test_done_early();
    test_coincident();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
